// File: rtl/y86_bus_mem.sv
// y86_bus_mem: byte-addressed memory responder for the y86_seq bus.
//   Reads are combinational. Each write is posted into a one-entry buffer and
//   drained into the byte array one byte per cycle over four cycles. A
//   valid/ready loader port preloads bytes whenever the write path is idle.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus_A        byte address (only [AW-1:0] used, wraps modulo 2^AW)
//   bus_out      write data from the core, little-endian
//   bus_WE       write strobe, one cycle per store
//   bus_RE       read strobe
//   bus_in       read data to the core, zero when bus_RE=0
//   ld_valid     loader byte valid
//   ld_ready     loader byte accepted this cycle
//   ld_addr      loader byte address
//   ld_data      loader byte
//   wr_busy      a posted write is still draining
//   err_overrun  sticky: bus_WE arrived while a write was draining
//   rd_count     saturating count of bus_RE cycles
//   wr_count     saturating count of accepted writes
module y86_bus_mem #(
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   bus_A,
  input  logic [31:0]   bus_out,
  input  logic          bus_WE,
  input  logic          bus_RE,
  output logic [31:0]   bus_in,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          wr_busy,
  output logic          err_overrun,
  output logic [CW-1:0] rd_count,
  output logic [CW-1:0] wr_count
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [AW-1:0] wbuf_addr;
  logic [31:0]   wbuf_data;
  logic [7:0]    mem [DEPTH];

  logic unused_bus_a_hi;
  assign unused_bus_a_hi = ^bus_A[31:AW];

  // rst is folded in so no handshake is reported while reset is held.
  assign ld_ready = ld_valid & (state == IDLE) & ~bus_WE & rst;

  // Combinational read; bytes of the posted write that are not yet committed
  // (index >= idx) override the stale array contents.
  always_comb begin
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_byte;
    bus_in  = '0;
    rd_addr = '0;
    rd_byte = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rd_addr = bus_A[AW-1:0] + AW'(k);
      rd_byte = mem[rd_addr];
      if (wr_busy) begin
        for (int unsigned j = 0; j < 4; j++) begin
          if (j >= 32'(idx) && rd_addr == wbuf_addr + AW'(j)) begin
            rd_byte = wbuf_data[8*j +: 8];
          end
        end
      end
      if (bus_RE) begin
        bus_in[8*k +: 8] = rd_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      wbuf_addr   <= '0;
      wbuf_data   <= '0;
      wr_busy     <= 1'b0;
      err_overrun <= 1'b0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      if (bus_RE && rd_count != '1) begin
        rd_count <= rd_count + CW'(1);
      end
      case (state)
        IDLE: begin
          if (bus_WE) begin
            wbuf_addr <= bus_A[AW-1:0];
            wbuf_data <= bus_out;
            idx       <= '0;
            state     <= DRAIN;
            wr_busy   <= 1'b1;
            if (wr_count != '1) begin
              wr_count <= wr_count + CW'(1);
            end
          end
        end
        DRAIN: begin
          // A store during drain is dropped; only the flag records it.
          if (bus_WE) begin
            err_overrun <= 1'b1;
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state   <= IDLE;
            wr_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single write port: drain wins; the loader can only hit in IDLE anyway.
  // While rst is low the FSM is IDLE and ld_ready is 0, so nothing is written.
  always_ff @(posedge clk) begin
    if (state == DRAIN) begin
      mem[wbuf_addr + AW'(idx)] <= wbuf_data[8*idx +: 8];
    end else if (ld_valid && ld_ready) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_y86_bus_mem.sv
module tb_y86_bus_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_A, bus_out;
  logic        bus_WE, bus_RE;
  logic [31:0] bus_in;
  logic        ld_valid, ld_ready;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        wr_busy, err_overrun;
  logic [15:0] rd_count, wr_count;

  logic [31:0] s_bus_in;
  logic        s_ld_ready, s_wr_busy, s_err_overrun;
  logic [1:0]  s_rd_count, s_wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  y86_bus_mem #(.AW(10), .CW(16)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_out(bus_out),
    .bus_WE(bus_WE), .bus_RE(bus_RE), .bus_in(bus_in),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .wr_busy(wr_busy), .err_overrun(err_overrun),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  // Narrow-counter copy to reach saturation in a few cycles.
  y86_bus_mem #(.AW(4), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_out(bus_out),
    .bus_WE(bus_WE), .bus_RE(bus_RE), .bus_in(s_bus_in),
    .ld_valid(ld_valid), .ld_ready(s_ld_ready), .ld_addr(ld_addr[3:0]),
    .ld_data(ld_data), .wr_busy(s_wr_busy), .err_overrun(s_err_overrun),
    .rd_count(s_rd_count), .wr_count(s_wr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    #1 check("ld_ready_load", {31'b0, ld_ready}, 32'd1);
    cyc();
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    bus_WE  = 1'b1;
    bus_A   = a;
    bus_out = d;
    cyc();
    bus_WE  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; bus_A = '0; bus_out = '0; bus_WE = 1'b0; bus_RE = 1'b0;
    ld_valid = 1'b1; ld_addr = '0; ld_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wr_busy", {31'b0, wr_busy}, 32'd0);
    check("rst_err", {31'b0, err_overrun}, 32'd0);
    check("rst_rd_count", {16'b0, rd_count}, 32'd0);
    check("rst_wr_count", {16'b0, wr_count}, 32'd0);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    ld_valid = 1'b0;
    rst = 1'b1;

    // Loader fill, ld_valid held high across all four bytes
    load(10'h000, 8'h8B);
    load(10'h001, 8'h45);
    load(10'h002, 8'h04);
    load(10'h003, 8'h00);
    ld_valid = 1'b0;
    bus_RE = 1'b1; bus_A = 32'h0;
    #1 check("fill_read", bus_in, 32'h0004458B);
    cyc();
    check("fill_rd_count", {16'b0, rd_count}, 32'd1);
    bus_RE = 1'b0;
    #1 check("re0_zero", bus_in, 32'h0);

    // Posted write with bypass during drain
    bus_WE = 1'b1; bus_A = 32'h10; bus_out = 32'hDEADBEEF;
    #1 check("wr_busy_pre", {31'b0, wr_busy}, 32'd0);
    cyc();
    bus_WE = 1'b0; bus_RE = 1'b1; bus_A = 32'h10;
    for (int i = 0; i < 4; i++) begin
      #1 check("bypass_read", bus_in, 32'hDEADBEEF);
      check("busy_drain", {31'b0, wr_busy}, 32'd1);
      cyc();
    end
    #1 check("busy_done", {31'b0, wr_busy}, 32'd0);
    check("post_read", bus_in, 32'hDEADBEEF);
    check("wr_count_1", {16'b0, wr_count}, 32'd1);
    cyc();
    check("rd_count_6", {16'b0, rd_count}, 32'd6);
    check("sat_rd_count", {30'b0, s_rd_count}, 32'd3);
    bus_RE = 1'b0;

    // Address wrap-around
    write(32'h3FE, 32'h11223344);
    repeat (4) cyc();
    check("wrap_idle", {31'b0, wr_busy}, 32'd0);
    bus_RE = 1'b1; bus_A = 32'h3FE;
    #1 check("wrap_read", bus_in, 32'h11223344);
    bus_A = 32'h0;
    #1 check("wrap_low", bus_in, 32'h00041122);
    bus_A = 32'hFFFF_F3FE;
    #1 check("wrap_hi_bits", bus_in, 32'h11223344);
    bus_RE = 1'b0;
    check("wr_count_2", {16'b0, wr_count}, 32'd2);

    // Overrun
    load(10'h040, 8'hA0);
    load(10'h041, 8'hA1);
    load(10'h042, 8'hA2);
    load(10'h043, 8'hA3);
    ld_valid = 1'b0;
    write(32'h20, 32'hCAFEF00D);
    bus_WE = 1'b1; bus_A = 32'h40; bus_out = 32'h12345678;
    #1 check("ovr_pre", {31'b0, err_overrun}, 32'd0);
    cyc();
    bus_WE = 1'b0;
    check("ovr_set", {31'b0, err_overrun}, 32'd1);
    repeat (3) cyc();
    check("ovr_idle", {31'b0, wr_busy}, 32'd0);
    check("ovr_sticky", {31'b0, err_overrun}, 32'd1);
    check("wr_count_3", {16'b0, wr_count}, 32'd3);
    bus_RE = 1'b1; bus_A = 32'h40;
    #1 check("ovr_dropped", bus_in, 32'hA3A2A1A0);
    bus_A = 32'h20;
    #1 check("ovr_first", bus_in, 32'hCAFEF00D);
    bus_RE = 1'b0;

    // Loader contention with a drain
    write(32'h60, 32'h55667788);
    ld_valid = 1'b1; ld_addr = 10'h050; ld_data = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      #1 check("ld_stall", {31'b0, ld_ready}, 32'd0);
      cyc();
    end
    #1 check("ld_go", {31'b0, ld_ready}, 32'd1);
    cyc();
    ld_valid = 1'b0;
    bus_RE = 1'b1; bus_A = 32'h50;
    #1 check("ld_byte", {24'b0, bus_in[7:0]}, 32'h5A);
    bus_A = 32'h60;
    #1 check("contend_wr", bus_in, 32'h55667788);
    bus_RE = 1'b0;
    check("wr_count_4", {16'b0, wr_count}, 32'd4);
    check("sat_wr_count", {30'b0, s_wr_count}, 32'd3);

    // Reset in the middle of a drain
    load(10'h070, 8'h01);
    load(10'h071, 8'h02);
    load(10'h072, 8'h03);
    load(10'h073, 8'h04);
    ld_valid = 1'b0;
    write(32'h70, 32'hF0E0D0C0);
    cyc();
    cyc();
    #1 rst = 1'b0;
    #1 check("mid_rst_busy", {31'b0, wr_busy}, 32'd0);
    check("mid_rst_err", {31'b0, err_overrun}, 32'd0);
    check("mid_rst_rd", {16'b0, rd_count}, 32'd0);
    check("mid_rst_wr", {16'b0, wr_count}, 32'd0);
    cyc();
    rst = 1'b1;
    bus_RE = 1'b1; bus_A = 32'h70;
    #1 check("mid_rst_mem", bus_in, 32'h0403D0C0);
    cyc();
    check("post_rst_rd", {16'b0, rd_count}, 32'd1);
    bus_RE = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
